// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment pattern decoder.
// Holds the segment pattern constants, the pattern decode function and the frame FSM state type.
package seg7_pkg;

   // Active-low segment patterns, bit0=a .. bit6=g
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   typedef enum logic {COLLECT, HOLD} state_t;

   // Returns {err, nibble}; unknown patterns give err=1, nibble=0
   function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         SEG_0:   r = 5'h00;
         SEG_1:   r = 5'h01;
         SEG_2:   r = 5'h02;
         SEG_3:   r = 5'h03;
         SEG_4:   r = 5'h04;
         SEG_5:   r = 5'h05;
         SEG_6:   r = 5'h06;
         SEG_7:   r = 5'h07;
         SEG_8:   r = 5'h08;
         SEG_9:   r = 5'h09;
         SEG_A:   r = 5'h0A;
         SEG_B:   r = 5'h0B;
         SEG_C:   r = 5'h0C;
         SEG_D:   r = 5'h0D;
         SEG_E:   r = 5'h0E;
         SEG_F:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational inverse 7-segment lookup.
// Ports: seg_n (active-low pattern in), nibble (decoded hex), err (pattern not recognised).
module seg7_lut
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] nibble,
   output logic       err
);

   assign {err, nibble} = seg7_decode(seg_n);

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Recovers per-digit hex values from a multiplexed active-low 7-segment bus and offers whole frames.
// Ports: clk, rst_n (async low); seg_n/dig_en_n bus in; frame_value/err/valid, frame_ready handshake; overrun/overrun_clr.
module seg7_pattern_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 2,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   dig_en_n,
   output logic [4*NUM_DIGITS-1:0] frame_value,
   output logic [NUM_DIGITS-1:0]   frame_err,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    overrun,
   input  logic                    overrun_clr
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);

   logic [6:0]              seg_q;
   logic [NUM_DIGITS-1:0]   en_q;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [4*NUM_DIGITS-1:0] work_val, work_val_nxt;
   logic [NUM_DIGITS-1:0]   work_err, work_err_nxt;
   logic [NUM_DIGITS-1:0]   filled, filled_nxt;
   logic [NUM_DIGITS-1:0]   cap_mask;
   logic [4*NUM_DIGITS-1:0] val_nxt;
   logic [NUM_DIGITS-1:0]   err_nxt;
   logic                    valid_nxt, overrun_nxt;
   state_t                  state, state_nxt;
   logic                    same, onehot, capture, complete, accept;
   logic [3:0]              nibble;
   logic                    dec_err;

   seg7_lut u_lut (
      .seg_n  (seg_q),
      .nibble (nibble),
      .err    (dec_err)
   );

   // A new sample extends the run only if it repeats the held one on a single enabled digit
   assign same    = (seg_n == seg_q) && (dig_en_n == en_q);
   assign onehot  = $onehot(~dig_en_n);
   // Capture exactly on the transition into saturation, so once per stable run
   assign capture = same && onehot && (cnt == CW'(STABLE_CYCLES - 1));
   assign cap_mask = capture ? ~en_q : '0;
   assign complete = &(filled | cap_mask);
   assign accept   = frame_valid && frame_ready;

   always_comb begin
      cnt_nxt = '0;
      if (same && onehot)
         cnt_nxt = (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + CW'(1);
   end

   always_comb begin
      work_val_nxt = work_val;
      work_err_nxt = work_err;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (cap_mask[d]) begin
            work_val_nxt[4*d +: 4] = dec_err ? 4'h0 : nibble;
            work_err_nxt[d]        = dec_err;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      filled_nxt  = filled | cap_mask;
      val_nxt     = frame_value;
      err_nxt     = frame_err;
      valid_nxt   = frame_valid;
      overrun_nxt = overrun & ~overrun_clr;
      case (state)
         COLLECT: begin
            if (complete) begin
               val_nxt    = work_val_nxt;
               err_nxt    = work_err_nxt;
               valid_nxt  = 1'b1;
               filled_nxt = '0;
               state_nxt  = HOLD;
            end
         end
         HOLD: begin
            if (complete) begin
               filled_nxt = '0;
               if (accept) begin
                  val_nxt = work_val_nxt;
                  err_nxt = work_err_nxt;
               end else begin
                  // Held frame wins; the new one is dropped
                  overrun_nxt = 1'b1;
               end
            end else if (accept) begin
               valid_nxt = 1'b0;
               state_nxt = COLLECT;
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q       <= '1;
         en_q        <= '1;
         cnt         <= '0;
         work_val    <= '0;
         work_err    <= '0;
         filled      <= '0;
         state       <= COLLECT;
         frame_value <= '0;
         frame_err   <= '0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         seg_q       <= seg_n;
         en_q        <= dig_en_n;
         cnt         <= cnt_nxt;
         work_val    <= work_val_nxt;
         work_err    <= work_err_nxt;
         filled      <= filled_nxt;
         state       <= state_nxt;
         frame_value <= val_nxt;
         frame_err   <= err_nxt;
         frame_valid <= valid_nxt;
         overrun     <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Self-checking bench for seg7_pattern_decoder.
// Frames expected by the bench are queued and compared as the DUT hands them over.
module tb_seg7_pattern_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] seg_n;
   logic [1:0] dig_en_n;
   logic [7:0] frame_value;
   logic [1:0] frame_err;
   logic       frame_valid;
   logic       frame_ready;
   logic       overrun;
   logic       overrun_clr;

   int n_vec = 0;
   int n_bad = 0;

   logic [9:0] sb[$];

   typedef struct {
      logic [6:0] s0;
      logic [6:0] s1;
      logic [7:0] val;
      logic [1:0] err;
   } vec_t;

   vec_t tbl[7];

   seg7_pattern_decoder #(
      .NUM_DIGITS    (2),
      .STABLE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_n       (seg_n),
      .dig_en_n    (dig_en_n),
      .frame_value (frame_value),
      .frame_err   (frame_err),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Handover monitor: valid&&ready seen here transfers on the next rising edge
   always @(negedge clk) begin
      if (rst_n && frame_valid && frame_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_frame: got %h expected none", {frame_err, frame_value});
         end else begin
            check("frame", {22'd0, frame_err, frame_value}, {22'd0, sb.pop_front()});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic hold(input logic [6:0] s, input logic [1:0] e, input int n);
      seg_n    = s;
      dig_en_n = e;
      step(n);
   endtask

   initial begin
      int lat;
      tbl[0] = '{7'b1000110, 7'b0001000, 8'hAC, 2'b00};
      tbl[1] = '{7'b0001110, 7'b0010010, 8'h5F, 2'b00};
      tbl[2] = '{7'b1000000, 7'b0010000, 8'h90, 2'b00};
      tbl[3] = '{7'b0000011, 7'b0100001, 8'hDB, 2'b00};
      tbl[4] = '{7'b0000110, 7'b1111111, 8'h0E, 2'b10};
      tbl[5] = '{7'b1111000, 7'b1111000, 8'h77, 2'b00};
      tbl[6] = '{7'b1010101, 7'b0000000, 8'h80, 2'b01};

      rst_n       = 1'b0;
      seg_n       = 7'h7F;
      dig_en_n    = 2'b11;
      frame_ready = 1'b0;
      overrun_clr = 1'b0;
      #3;
      check("rst_value", {24'd0, frame_value}, 32'h0);
      check("rst_err", {30'd0, frame_err}, 32'h0);
      check("rst_valid", {31'd0, frame_valid}, 32'h0);
      check("rst_overrun", {31'd0, overrun}, 32'h0);
      #10;
      rst_n = 1'b1;
      step(2);

      // Latency and value of the first frame
      hold(7'b1111001, 2'b10, 6);
      seg_n    = 7'b0110000;
      dig_en_n = 2'b01;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         step(1);
         if (frame_valid) begin
            lat = k;
            break;
         end
      end
      check("latency", lat, 32'd5);
      check("t1_value", {24'd0, frame_value}, 32'h31);
      check("t1_err", {30'd0, frame_err}, 32'h0);
      step(1);
      sb.push_back({2'b00, 8'h31});
      frame_ready = 1'b1;
      step(2);

      // Table of frames, including undecodable patterns
      for (int i = 0; i < 7; i++) begin
         sb.push_back({tbl[i].err, tbl[i].val});
         hold(tbl[i].s0, 2'b10, 6);
         hold(tbl[i].s1, 2'b01, 6);
         step(1);
      end

      // Short runs must not capture
      hold(7'b0010010, 2'b10, 3);
      hold(7'b0000010, 2'b10, 3);
      hold(7'b1111000, 2'b10, 3);
      hold(7'b0011001, 2'b01, 6);
      check("short_run_valid", {31'd0, frame_valid}, 32'h0);
      sb.push_back({2'b00, 8'h42});
      hold(7'b0100100, 2'b10, 6);
      step(2);

      // Overrun while the consumer stalls
      frame_ready = 1'b0;
      hold(7'b1111001, 2'b10, 6);
      hold(7'b0100100, 2'b01, 6);
      hold(7'b0110000, 2'b10, 6);
      hold(7'b0011001, 2'b01, 6);
      hold(7'b0010010, 2'b10, 6);
      hold(7'b0000010, 2'b01, 6);
      check("held_value", {24'd0, frame_value}, 32'h21);
      check("overrun_set", {31'd0, overrun}, 32'h1);
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      check("overrun_clr", {31'd0, overrun}, 32'h0);
      sb.push_back({2'b00, 8'h21});
      frame_ready = 1'b1;
      step(2);

      // Accept on the same edge the next frame completes
      frame_ready = 1'b0;
      sb.push_back({2'b00, 8'h63});
      hold(7'b0110000, 2'b10, 6);
      hold(7'b0000010, 2'b01, 6);
      hold(7'b0000000, 2'b10, 6);
      seg_n    = 7'b0010000;
      dig_en_n = 2'b01;
      step(4);
      frame_ready = 1'b1;
      step(1);
      frame_ready = 1'b0;
      check("swap_valid", {31'd0, frame_valid}, 32'h1);
      check("swap_value", {24'd0, frame_value}, 32'h98);
      check("swap_overrun", {31'd0, overrun}, 32'h0);
      sb.push_back({2'b00, 8'h98});
      frame_ready = 1'b1;
      step(2);

      // Reset mid-frame discards the partial frame
      hold(7'b1111001, 2'b10, 6);
      rst_n = 1'b0;
      #3;
      check("mid_rst_value", {24'd0, frame_value}, 32'h0);
      check("mid_rst_err", {30'd0, frame_err}, 32'h0);
      check("mid_rst_valid", {31'd0, frame_valid}, 32'h0);
      check("mid_rst_overrun", {31'd0, overrun}, 32'h0);
      step(2);
      rst_n = 1'b1;
      hold(7'b0100100, 2'b01, 10);
      check("post_rst_valid", {31'd0, frame_valid}, 32'h0);
      hold(7'h7F, 2'b11, 2);

      check("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
